window3x3_gen: RTL and testbench
================================

# window3x3_gen

3x3 sliding-window former sitting directly downstream of the 4-bank BRAM line buffer and its streaming controller. Each accepted cycle it takes one column of pixels from all four row banks. It uses the controller's `Sel` (the bank currently being written) to pick the three completed rows in oldest-to-newest order, then shifts them into a 3x3 register window. It emits one window per interior column, with row/column coordinates and an end-of-frame pulse, to the downstream stencil/convolution stage.

## Interface
- `IMG_W`, 512, pixels per image row; column counter wraps at `IMG_W-1`.
- `ROWS_OUT`, 510, window rows produced per frame (image height minus 2).
- `PIX_W`, 8, bits per pixel.
- `SELECT`, 2, width of `Sel` (4 banks).
- `CLK`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `SM_EN`  in  1  column valid: bank outputs carry a column this cycle.
- `stall`  in  1  hold: when high, no column is accepted regardless of `SM_EN`.
- `Sel`  in  `SELECT`  index of the bank being written; the other three hold completed rows.
- `bank_dout`  in  `4*PIX_W`  bank k pixel at bits `[k*PIX_W +: PIX_W]`.
- `frame_done`  in  1  one-cycle pulse from the controller at frame end; returns the block to IDLE.
- `win_valid`  out  1  window output valid.
- `win`  out  `9*PIX_W`  window pixel (r,c) at `[(3*r+c)*PIX_W +: PIX_W]`; r=0 oldest row, c=0 oldest column.
- `win_col`  out  9  center column index of the window (1..`IMG_W-2`).
- `win_row`  out  9  window row index (0..`ROWS_OUT-1`).
- `frame_last`  out  1  pulse with the last window of the frame.

## Operation
- Accept condition `acc = SM_EN & ~stall`. No state, counter or shift register changes unless `acc` is high, except on `frame_done` or `rst`.
- Row mapping for each accepted column, with all indices mod 4:
  - top (r=0) = bank `Sel+1`.
  - mid (r=1) = bank `Sel+2`.
  - bot (r=2) = bank `Sel+3`.
- Shift: for each row r, `c0 <= c1`, `c1 <= c2`, `c2 <= new pixel`.
- `col_cnt` (9 bits) counts accepted columns 0..`IMG_W-1` and wraps to 0 after `IMG_W-1`.
- `row_cnt` (9 bits) increments when an accepted column has `col_cnt == IMG_W-1`.
- FSM states: IDLE, FILL, RUN.
  - IDLE: on `acc`, go to FILL. This column counts as column 0.
  - FILL: on `acc` with `col_cnt == 1` (second column), go to RUN. That column completes the shift registers only; no window is emitted for it.
  - RUN: every `acc` with `col_cnt` in 2..`IMG_W-1` emits a window with `win_col = col_cnt-1` and `win_row = row_cnt`. On the `acc` with `col_cnt == IMG_W-1`, go to FILL (the next row starts at column 0).
  - Any state: `frame_done` goes to IDLE and clears `col_cnt`, `row_cnt` and the shift registers. `frame_done` overrides a simultaneous `acc`.
- Stale columns from the previous row remain in the shift registers during FILL. They are never emitted, because `win_valid` requires RUN.
- `frame_last` is asserted with the window where `row_cnt == ROWS_OUT-1` and `col_cnt == IMG_W-1`. `row_cnt` then wraps to 0.
- `Sel` is sampled in the same cycle as `bank_dout`; it may change between any two accepted columns.

## Timing
- All outputs are registered; latency is one cycle from the accepting edge.
  - `win_valid`, `win`, `win_col`, `win_row` and `frame_last` update on the rising edge that samples the completing column.
  - `win_valid` and `frame_last` are single-cycle unless further accepts follow.
- Throughput: one window per cycle while `acc` is held.
  - Exactly `IMG_W-2` (510) windows per row.
  - 2-cycle bubble (FILL) at each row start.
- Reset values: state IDLE; `col_cnt = 0`, `row_cnt = 0`; all shift registers 0; `win_valid = 0`, `win = 0`, `win_col = 0`, `win_row = 0`, `frame_last = 0`.
- Reset mid-row takes effect immediately (asynchronous). After release, the next `acc` is treated as column 0 of row 0.
- When `stall` is high, `win_valid` goes low the next cycle; `win` holds its last value.

## Test plan
- Reset: assert `rst` mid-stream → all outputs 0 within the same cycle, no clock edge needed. After release, first `acc` → column 0, and `win_valid` stays 0 for 2 accepts.
- Bank ordering: `Sel=0`, bank1/2/3 = 10+c/20+c/30+c for column c, 5 accepts → windows at `win_col` 1,2,3. The first has r0={10,11,12}, r1={20,21,22}, r2={30,31,32}.
- Rotation: `Sel=3` with the same data on banks 0/1/2 → r0 from bank0, r1 from bank1, r2 from bank2. Repeat for `Sel=1,2`.
- Row wrap: 1024 continuous accepts → exactly 1020 `win_valid` pulses. None for the first two columns of row 1. `win_row` steps from 0 to 1.
- Stall: toggle `stall` every other cycle with `SM_EN=1` → window count and contents identical to the unstalled run, with `win_valid` only on accepted cycles.
- Frame end: `ROWS_OUT*IMG_W` accepts → `frame_last` exactly once, with `win_row=509`, `win_col=510`. A following `frame_done` → IDLE with counters 0.

Source files
------------

// File: rtl/window3x3_gen_if.sv
// Bus between the line-buffer controller, the 3x3 window former and the
// downstream stencil stage: column input side plus window output side.
interface window3x3_gen_if #(
  parameter int PIX_W  = 8,
  parameter int SELECT = 2
);
  // Column input from the line-buffer banks and controller
  logic                 SM_EN;
  logic                 stall;
  logic [SELECT-1:0]    Sel;
  logic [4*PIX_W-1:0]   bank_dout;
  logic                 frame_done;

  // Window output toward the stencil stage
  logic                 win_valid;
  logic [9*PIX_W-1:0]   win;
  logic [8:0]           win_col;
  logic [8:0]           win_row;
  logic                 frame_last;

  // Producer of columns / consumer of windows
  modport master (
    output SM_EN, stall, Sel, bank_dout, frame_done,
    input  win_valid, win, win_col, win_row, frame_last
  );

  // The window former itself
  modport slave (
    input  SM_EN, stall, Sel, bank_dout, frame_done,
    output win_valid, win, win_col, win_row, frame_last
  );
endinterface

// File: rtl/window3x3_gen.sv
// 3x3 sliding-window former. Takes one column per accepted cycle from the
// four row banks, orders the three completed rows oldest-to-newest using Sel,
// shifts them into a 3x3 register window and emits one registered window per
// interior column with its coordinates and an end-of-frame marker.
module window3x3_gen #(
  parameter int IMG_W    = 512,
  parameter int ROWS_OUT = 510,
  parameter int PIX_W    = 8,
  parameter int SELECT   = 2
) (
  input  logic            CLK,
  input  logic            rst,
  window3x3_gen_if.slave  bus
);

  localparam int unsigned NBANK    = 4;
  localparam logic [8:0]  COL_LAST = 9'(IMG_W - 1);
  localparam logic [8:0]  ROW_LAST = 9'(ROWS_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [8:0] col_q, col_d;
  logic [8:0] row_q, row_d;

  // Window shift registers, element (r,c) at index 3*r+c
  logic [8:0][PIX_W-1:0] sh_q, sh_d;

  // Registered outputs
  logic                  win_valid_q, win_valid_d;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic [8:0]            win_col_q, win_col_d;
  logic [8:0]            win_row_q, win_row_d;
  logic                  frame_last_q, frame_last_d;

  logic                  acc;
  logic                  emit;
  logic                  last;
  logic [2:0][PIX_W-1:0] new_pix;

  assign acc = bus.SM_EN & ~bus.stall;

  // Pick the three completed rows, oldest first, starting one bank past Sel
  always_comb begin
    logic [SELECT-1:0] idx;
    idx     = '0;
    new_pix = '0;
    for (int unsigned r = 0; r < 3; r++) begin
      idx        = bus.Sel + SELECT'(r + 1);
      new_pix[r] = bus.bank_dout[int'(idx) % NBANK * PIX_W +: PIX_W];
    end
  end

  // Next-state logic for FSM, counters, shift window and output registers
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sh_d    = sh_q;
    emit    = 1'b0;
    last    = 1'b0;

    if (bus.frame_done) begin
      state_d = IDLE;
      col_d   = '0;
      row_d   = '0;
      sh_d    = '0;
    end else if (acc) begin
      for (int unsigned r = 0; r < 3; r++) begin
        sh_d[3*r]     = sh_q[3*r+1];
        sh_d[3*r + 1] = sh_q[3*r+2];
        sh_d[3*r + 2] = new_pix[r];
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 9'd1;
      end else begin
        col_d = col_q + 9'd1;
      end

      unique case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (col_q == 9'd1) state_d = RUN;
        end
        RUN: begin
          emit = 1'b1;
          last = (row_q == ROW_LAST) && (col_q == COL_LAST);
          if (col_q == COL_LAST) state_d = FILL;
        end
        default: state_d = IDLE;
      endcase
    end

    // Window content and coordinates only move when a window is emitted,
    // so a stall or the FILL bubble leaves the last window visible.
    win_valid_d  = emit;
    frame_last_d = last;
    win_d        = emit ? sh_d : win_q;
    win_col_d    = emit ? col_q - 9'd1 : win_col_q;
    win_row_d    = emit ? row_q : win_row_q;
  end

  // FSM state register
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Counters, shift window and registered outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      sh_q         <= '0;
      win_valid_q  <= 1'b0;
      win_q        <= '0;
      win_col_q    <= '0;
      win_row_q    <= '0;
      frame_last_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sh_q         <= sh_d;
      win_valid_q  <= win_valid_d;
      win_q        <= win_d;
      win_col_q    <= win_col_d;
      win_row_q    <= win_row_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign bus.win_valid  = win_valid_q;
  assign bus.win        = win_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.frame_last = frame_last_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Scoreboard bench for window3x3_gen with a reduced image size.
module tb_window3x3_gen;

  localparam int W  = 16;
  localparam int R  = 5;
  localparam int PW = 8;

  logic CLK = 1'b0;
  logic rst;

  window3x3_gen_if #(.PIX_W(PW), .SELECT(2)) bus ();

  window3x3_gen #(
    .IMG_W(W),
    .ROWS_OUT(R),
    .PIX_W(PW),
    .SELECT(2)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [9*PW-1:0] win;
    logic [8:0]      col;
    logic [8:0]      row;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int checks = 0;
  int passes = 0;
  int n_win  = 0;
  int n_last = 0;
  int mc     = 0;
  int my     = 0;

  // Image pixel for window row rr of output row y at column c
  function automatic logic [7:0] pix(input int rr, input int y, input int c);
    return 8'(10 * (rr + 1) + c + 3 * y);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Drive one cycle; the model advances only on an accepted column
  task automatic step(input logic en, input logic st, input logic [1:0] sel, input logic fd);
    logic [31:0] banks;
    exp_t e;
    int s;
    s = int'(sel);
    banks = $urandom;
    for (int rr = 0; rr < 3; rr++)
      banks[((s + 1 + rr) % 4) * 8 +: 8] = pix(rr, my, mc);
    bus.SM_EN      = en;
    bus.stall      = st;
    bus.Sel        = sel;
    bus.bank_dout  = banks;
    bus.frame_done = fd;
    if (fd) begin
      mc = 0;
      my = 0;
    end else if (en && !st) begin
      if (mc >= 2) begin
        e.win = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int j = 0; j < 3; j++)
            e.win[(3 * rr + j) * 8 +: 8] = pix(rr, my, mc - 2 + j);
        e.col  = 9'(mc - 1);
        e.row  = 9'(my);
        e.last = (my == R - 1) && (mc == W - 1);
        exp_q.push_back(e);
      end
      if (mc == W - 1) begin
        mc = 0;
        my = (my == R - 1) ? 0 : my + 1;
      end else begin
        mc++;
      end
    end
    @(posedge CLK);
    #1;
    bus.SM_EN      = 1'b0;
    bus.stall      = 1'b0;
    bus.frame_done = 1'b0;
  endtask

  task automatic drain();
    @(negedge CLK);
    #1;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_win_valid"}, bus.win_valid, 0);
    chk({tag, "_win"}, bus.win, 0);
    chk({tag, "_win_col"}, bus.win_col, 0);
    chk({tag, "_win_row"}, bus.win_row, 0);
    chk({tag, "_frame_last"}, bus.frame_last, 0);
  endtask

  // Monitor: pop the expected window whenever the DUT presents one
  always @(negedge CLK) begin
    if (!rst) begin
      if (bus.win_valid) begin
        n_win++;
        if (bus.frame_last) n_last++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_window: got win_valid=1 col=%0d row=%0d expected no window",
                   bus.win_col, bus.win_row);
        end else begin
          mon_e = exp_q.pop_front();
          chk("win", bus.win, mon_e.win);
          chk("win_col", bus.win_col, mon_e.col);
          chk("win_row", bus.win_row, mon_e.row);
          chk("frame_last", bus.frame_last, mon_e.last);
        end
      end else begin
        chk("frame_last_idle", bus.frame_last, 0);
      end
    end
  end

  initial begin
    int n0;
    int l0;
    bus.SM_EN      = 1'b0;
    bus.stall      = 1'b0;
    bus.Sel        = '0;
    bus.bank_dout  = '0;
    bus.frame_done = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 chk_zero("reset");
    @(negedge CLK);
    #1 rst = 1'b0;

    // Bank ordering with Sel=0: windows at columns 1..3
    n0 = n_win;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    chk("sel0_count", n_win - n0, 3);

    // Mid-stream asynchronous reset while a window is valid
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    rst = 1'b1;
    #1 chk_zero("midreset");
    exp_q.delete();
    mc = 0;
    my = 0;
    @(negedge CLK);
    #1 rst = 1'b0;

    // Rotation: remaining Sel values, frame_done overriding a simultaneous accept
    for (int k = 0; k < 3; k++) begin
      logic [1:0] sel;
      sel = (k == 0) ? 2'd3 : (k == 1) ? 2'd1 : 2'd2;
      n0 = n_win;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, sel, 1'b0);
      drain();
      chk("rot_count", n_win - n0, 3);
      step(1'b1, 1'b0, sel, 1'b1);
    end

    // Row wrap: two full rows, Sel changing every column
    n0 = n_win;
    for (int i = 0; i < 2 * W; i++) step(1'b1, 1'b0, 2'($urandom), 1'b0);
    drain();
    chk("wrap_count", n_win - n0, 2 * (W - 2));
    step(1'b0, 1'b0, 2'd0, 1'b1);

    // Stall every other cycle: same windows as the unstalled run
    n0 = n_win;
    for (int i = 0; i < 4 * W; i++) step(1'b1, 1'(i % 2), 2'($urandom), 1'b0);
    drain();
    chk("stall_count", n_win - n0, 2 * (W - 2));
    step(1'b0, 1'b0, 2'd0, 1'b1);

    // Full frame: exactly one frame_last, then frame_done back to row 0 col 0
    n0 = n_win;
    l0 = n_last;
    for (int i = 0; i < R * W; i++) step(1'b1, 1'b0, 2'($urandom), 1'b0);
    drain();
    chk("frame_count", n_win - n0, R * (W - 2));
    chk("frame_last_count", n_last - l0, 1);
    step(1'b0, 1'b0, 2'd0, 1'b1);
    n0 = n_win;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
    drain();
    chk("after_done_count", n_win - n0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
